// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter peripheral: register offsets,
// FSM state encodings, MODE constants and CTRL bit layout. Also imported by
// the peripheral bridge and the CP0 interrupt wiring.
package timer_counter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned CTRL_W = 4;

    // Register offsets, decoded from byte-address bits [3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL.MODE values; anything other than AUTO_RELOAD counts once
    localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

    // CTRL bit indices
    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_MODE_LO = 1;
    localparam int unsigned CTRL_MODE_HI = 2;
    localparam int unsigned CTRL_IM_BIT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Writable CTRL field layout, MSB first: IM, MODE[1:0], EN
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    function automatic logic is_auto_reload(input logic [1:0] mode);
        return (mode == MODE_AUTO_RELOAD);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counting timer with one-shot and
// auto-reload modes and a maskable level interrupt.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   Addr   in   [29:0] word address (byte address bits [31:2]); only the two
//               LSBs (byte bits [3:2]) select the register
//   WE     in   write strobe, already qualified by address range
//   Din    in   [31:0] write data
//   Dout   out  [31:0] read data, combinational on the register select
//   IRQ    out  interrupt request, level (irq_f & CTRL.IM)
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    tc_state_e           r_state;
    tc_state_e           w_state_nxt;
    tc_ctrl_t            r_ctrl;
    logic [DATA_W-1:0]   r_preset;
    logic [DATA_W-1:0]   r_count;
    logic                r_irq_f;

    logic [1:0]          w_reg_sel;
    logic                w_wr_ctrl;
    logic                w_wr_preset;
    logic                w_auto;
    logic                w_cnt_le1;
    logic                w_addr_unused;

    // FSM datapath controls
    logic                w_load_cnt;
    logic                w_dec_cnt;
    logic                w_zero_cnt;
    logic                w_set_irq;
    logic                w_clr_irq;
    logic                w_clr_en;

    // Address decode; upper word-address bits are range-decoded by the bridge
    assign w_reg_sel     = Addr[1:0];
    assign w_addr_unused = ^Addr[29:2];
    assign w_wr_ctrl     = WE && (w_reg_sel == OFF_CTRL);
    assign w_wr_preset   = WE && (w_reg_sel == OFF_PRESET);
    assign w_auto        = is_auto_reload(r_ctrl.mode);
    assign w_cnt_le1     = (r_count <= DATA_W'(1));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_ctrl.en) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_CNT;
            ST_CNT: begin
                if (!r_ctrl.en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_le1) begin
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs driving the counter, CTRL.EN and irq_f
    always_comb begin
        w_load_cnt = 1'b0;
        w_dec_cnt  = 1'b0;
        w_zero_cnt = 1'b0;
        w_set_irq  = 1'b0;
        w_clr_irq  = 1'b0;
        w_clr_en   = 1'b0;
        case (r_state)
            ST_LOAD: w_load_cnt = 1'b1;
            ST_CNT: begin
                if (r_ctrl.en) begin
                    if (w_cnt_le1) begin
                        // PRESET of 0 lands here too, so it behaves like 1
                        w_zero_cnt = 1'b1;
                        w_set_irq  = 1'b1;
                    end else begin
                        w_dec_cnt = 1'b1;
                    end
                end
            end
            ST_INT: begin
                if (w_auto) begin
                    w_clr_irq = 1'b1;
                end else begin
                    w_clr_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // CTRL register; a bus write beats the one-shot EN clear in INT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= tc_ctrl_t'(Din[CTRL_W-1:0]);
        end else if (w_clr_en) begin
            r_ctrl.en <= 1'b0;
        end
    end

    // PRESET register; only sampled into COUNT on LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_preset <= '0;
        end else if (w_wr_preset) begin
            r_preset <= Din;
        end
    end

    // COUNT register; not bus-writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load_cnt) begin
            r_count <= r_preset;
        end else if (w_dec_cnt) begin
            r_count <= r_count - DATA_W'(1);
        end else if (w_zero_cnt) begin
            r_count <= '0;
        end
    end

    // Interrupt flag; a terminal count in the same cycle as a CTRL write is
    // kept so the event is not lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_f <= 1'b0;
        end else if (w_set_irq) begin
            r_irq_f <= 1'b1;
        end else if (w_wr_ctrl || w_clr_irq) begin
            r_irq_f <= 1'b0;
        end
    end

    // Read mux
    always_comb begin
        Dout = '0;
        case (w_reg_sel)
            OFF_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, r_ctrl};
            OFF_PRESET: Dout = r_preset;
            OFF_COUNT:  Dout = r_count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = r_irq_f & r_ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register-access vector table plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_timer_counter;
    import timer_counter_pkg::*;

    localparam logic [29:0] TC_BASE = 30'h1FC0;  // TC0 at byte 0x7F00

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    string       name_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] din;
        logic [1:0]  rd_off;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [31:0] e);
        name_q.push_back(nm);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] act);
        string       nm;
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
            return;
        end
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        if (act === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    task automatic check_rd(input string nm, input logic [1:0] off, input logic [31:0] e);
        push_exp(nm, e);
        Addr = TC_BASE | 30'(off);
        #1;
        pop_cmp(Dout);
    endtask

    task automatic check_irq(input string nm, input logic e);
        push_exp(nm, 32'(e));
        #1;
        pop_cmp(32'(IRQ));
    endtask

    task automatic bus_wr(input logic [1:0] off, input logic [31:0] data);
        Addr = TC_BASE | 30'(off);
        Din  = data;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic settle();
        bus_wr(OFF_CTRL, 32'h0);
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = TC_BASE;
        Din   = '0;

        //           we    off         din            rd_off      exp
        vecs[0]  = '{1'b0, OFF_CTRL,   32'h0,         OFF_CTRL,   32'h0};
        vecs[1]  = '{1'b0, OFF_CTRL,   32'h0,         OFF_PRESET, 32'h0};
        vecs[2]  = '{1'b0, OFF_CTRL,   32'h0,         OFF_COUNT,  32'h0};
        vecs[3]  = '{1'b0, OFF_CTRL,   32'h0,         2'd3,       32'h0};
        vecs[4]  = '{1'b1, OFF_PRESET, 32'hDEADBEEF,  OFF_PRESET, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, OFF_CTRL,   32'hFFFFFFF6,  OFF_CTRL,   32'h6};
        vecs[6]  = '{1'b1, OFF_COUNT,  32'h12345678,  OFF_COUNT,  32'h0};
        vecs[7]  = '{1'b1, 2'd3,       32'hFFFFFFFF,  2'd3,       32'h0};
        vecs[8]  = '{1'b0, OFF_CTRL,   32'h0,         OFF_PRESET, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, OFF_CTRL,   32'h0,         OFF_CTRL,   32'h6};
        vecs[10] = '{1'b1, OFF_CTRL,   32'h0,         OFF_CTRL,   32'h0};
        vecs[11] = '{1'b1, OFF_PRESET, 32'h0,         OFF_PRESET, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and plain register access
        check_irq("reset_irq", 1'b0);
        for (int i = 0; i < 12; i++) begin
            Addr = TC_BASE | 30'(vecs[i].off);
            Din  = vecs[i].din;
            WE   = vecs[i].we;
            tick();
            WE   = 1'b0;
            check_rd($sformatf("vec%0d", i), vecs[i].rd_off, vecs[i].exp);
        end
        check_irq("vec_irq", 1'b0);

        // One-shot, PRESET=5, IM=1
        bus_wr(OFF_PRESET, 32'd5);
        bus_wr(OFF_CTRL, 32'h9);                       // E0
        tick();                                        // E1
        for (int k = 2; k <= 6; k++) begin
            tick();
            check_rd($sformatf("os_count_e%0d", k), OFF_COUNT, 32'(7 - k));
            check_irq($sformatf("os_irq_e%0d", k), 1'b0);
        end
        tick();                                        // E7
        check_irq("os_irq_e7", 1'b1);
        check_rd("os_count_e7", OFF_COUNT, 32'h0);
        tick();                                        // E8
        check_rd("os_ctrl_en_clr", OFF_CTRL, 32'h8);
        repeat (3) tick();
        check_irq("os_irq_held", 1'b1);
        check_rd("os_count_held", OFF_COUNT, 32'h0);
        bus_wr(OFF_CTRL, 32'h0);
        check_irq("os_irq_drop", 1'b0);
        repeat (2) tick();

        // Auto-reload, PRESET=2: 1-cycle pulse every 5 cycles
        bus_wr(OFF_PRESET, 32'd2);
        bus_wr(OFF_CTRL, 32'hB);                       // E0
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_irq($sformatf("auto_irq_e%0d", k), (k >= 4) && (((k - 4) % 5) == 0));
        end
        settle();

        // Masked one-shot: counts down and clears EN, IRQ never rises
        bus_wr(OFF_PRESET, 32'd5);
        bus_wr(OFF_CTRL, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_irq($sformatf("mask_irq_e%0d", k), 1'b0);
        end
        check_rd("mask_count", OFF_COUNT, 32'h0);
        check_rd("mask_ctrl", OFF_CTRL, 32'h0);
        bus_wr(OFF_CTRL, 32'h8);                       // unmask clears stale flag
        check_irq("mask_unmask_irq", 1'b0);
        settle();

        // Disable mid-count holds COUNT, re-enable reloads PRESET
        bus_wr(OFF_PRESET, 32'd10);
        bus_wr(OFF_CTRL, 32'h9);                       // E0
        repeat (5) tick();                             // E5
        check_rd("dis_count_e5", OFF_COUNT, 32'd7);
        bus_wr(OFF_CTRL, 32'h8);                       // E6: EN cleared
        check_rd("dis_count_e6", OFF_COUNT, 32'd6);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_rd($sformatf("dis_hold%0d", k), OFF_COUNT, 32'd6);
        end
        check_irq("dis_irq", 1'b0);
        bus_wr(OFF_CTRL, 32'h9);                       // E0'
        check_rd("reen_e0", OFF_COUNT, 32'd6);
        tick();
        check_rd("reen_e1", OFF_COUNT, 32'd6);
        tick();
        check_rd("reen_e2", OFF_COUNT, 32'd10);
        tick();
        check_rd("reen_e3", OFF_COUNT, 32'd9);
        settle();

        // CTRL write in the INT cycle: written EN survives
        bus_wr(OFF_PRESET, 32'd1);
        bus_wr(OFF_CTRL, 32'h9);                       // E0
        repeat (2) tick();                             // E2
        check_rd("int_count_e2", OFF_COUNT, 32'd1);
        tick();                                        // E3: now in INT
        check_irq("int_irq_e3", 1'b1);
        bus_wr(OFF_CTRL, 32'h9);                       // E4
        check_rd("int_ctrl_kept", OFF_CTRL, 32'h9);
        check_irq("int_irq_cleared", 1'b0);
        repeat (2) tick();                             // E6
        check_rd("int_restart_count", OFF_COUNT, 32'd1);
        tick();                                        // E7
        check_irq("int_restart_irq", 1'b1);
        settle();

        // PRESET=0 behaves like 1
        bus_wr(OFF_PRESET, 32'd0);
        bus_wr(OFF_CTRL, 32'h9);                       // E0
        repeat (2) tick();                             // E2
        check_irq("p0_irq_e2", 1'b0);
        tick();                                        // E3
        check_irq("p0_irq_e3", 1'b1);
        check_rd("p0_count_e3", OFF_COUNT, 32'h0);
        settle();

        // Asynchronous reset mid-count
        bus_wr(OFF_PRESET, 32'd100);
        bus_wr(OFF_CTRL, 32'h9);                       // E0
        repeat (4) tick();                             // E4
        check_rd("rst_pre_count", OFF_COUNT, 32'd98);
        #2;
        reset = 1'b1;
        check_rd("rst_count", OFF_COUNT, 32'h0);
        check_rd("rst_ctrl", OFF_CTRL, 32'h0);
        check_rd("rst_preset", OFF_PRESET, 32'h0);
        check_irq("rst_irq", 1'b0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check_rd("rst_after_count", OFF_COUNT, 32'h0);

        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
